// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read-channel (AR/R) bundle with master/slave views
interface axi_rd_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4
);
    // AR channel
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [IW-1:0] arid;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;

    // R channel
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [IW-1:0] rid;

    // Initiator of read transactions
    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    // Responder to read transactions
    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - 2:1 AXI4 read arbiter (IFU=M0, LSU=M1), one outstanding burst; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module axi_rd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_rd_if.slave    m0,
    axi_rd_if.slave    m1,
    axi_rd_if.master   s,
    output logic [1:0] grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
`ifdef ARB_ROUND_ROBIN_EN
    // 0 = M0 was served last, 1 = M1 was served last
    logic       last_q, last_d;
`endif

    logic [1:0]    winner;
    logic          g_arvalid;
    logic          g_rready;
    logic [AW-1:0] g_araddr;
    logic [IW-1:0] g_arid;
    logic [DW-1:0] r_data;

    assign grant = grant_q;

    // Pick the next owner from the current requests (only consumed in IDLE)
    always_comb begin
        winner = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        if (m0.arvalid && m1.arvalid) begin
            winner = last_q ? 2'b01 : 2'b10;
        end else if (m1.arvalid) begin
            winner = 2'b10;
        end else if (m0.arvalid) begin
            winner = 2'b01;
        end
`else
        if (m1.arvalid) begin
            winner = 2'b10;
        end else if (m0.arvalid) begin
            winner = 2'b01;
        end
`endif
    end

    // Select the owner's handshake inputs and AR payload
    always_comb begin
        if (grant_q[1]) begin
            g_arvalid = m1.arvalid;
            g_rready  = m1.rready;
            g_araddr  = m1.araddr;
            g_arid    = m1.arid;
        end else begin
            g_arvalid = m0.arvalid;
            g_rready  = m0.rready;
            g_araddr  = m0.araddr;
            g_arid    = m0.arid;
        end
    end

    // State, grant and tie-break history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state: grant is only ever loaded in IDLE and cleared on leaving ADDR/DATA
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (winner != 2'b00) begin
                    grant_d = winner;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Owner withdrew its request before acceptance: abandon it
                if (!g_arvalid) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (s.arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s.rvalid && g_rready && s.rlast) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = grant_q[1];
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Handshake routing: AR signals live only in ADDR, R signals only in DATA
    always_comb begin
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        s.araddr   = g_araddr;
        s.arid     = g_arid;
        s.arlen    = grant_q[1] ? m1.arlen   : m0.arlen;
        s.arsize   = grant_q[1] ? m1.arsize  : m0.arsize;
        s.arburst  = grant_q[1] ? m1.arburst : m0.arburst;
        case (state_q)
            ST_ADDR: begin
                s.arvalid  = g_arvalid;
                m0.arready = grant_q[0] & s.arready;
                m1.arready = grant_q[1] & s.arready;
            end
            ST_DATA: begin
                s.rready  = g_rready;
                m0.rvalid = grant_q[0] & s.rvalid;
                m1.rvalid = grant_q[1] & s.rvalid;
            end
            default: begin
            end
        endcase
    end

    // R payload goes to both masters; only the owner sees rvalid
    assign r_data   = s.rdata;
    assign m0.rdata = r_data;
    assign m1.rdata = r_data;
    assign m0.rresp = s.rresp;
    assign m1.rresp = s.rresp;
    assign m0.rlast = s.rlast;
    assign m1.rlast = s.rlast;
    assign m0.rid   = s.rid;
    assign m1.rid   = s.rid;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;

    int checks   = 0;
    int failures = 0;
    int nbeat    = 0;

    logic [1:0]  exp_g [9];
    logic [31:0] exp_beats [4];

    axi_rd_if #(.AW(32), .DW(32), .IW(4)) m0_if ();
    axi_rd_if #(.AW(32), .DW(32), .IW(4)) m1_if ();
    axi_rd_if #(.AW(32), .DW(32), .IW(4)) s_if ();

    axi_rd_arbiter #(.AW(32), .DW(32), .IW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0;
        m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.rready = 0;
        m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0;
        m1_if.arsize = 3'd2; m1_if.arburst = 2'd1; m1_if.rready = 0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0;
        s_if.rlast = 0; s_if.rid = '0;
    endtask

    task automatic beat(input string tag, input logic rv, input logic [31:0] d,
                        input logic lst, input logic rr);
        s_if.rvalid = rv; s_if.rdata = d; s_if.rlast = lst; m0_if.rready = rr;
        #1;
        chk({tag, "_m0_rvalid"}, m0_if.rvalid, rv);
        chk({tag, "_m1_rvalid"}, m1_if.rvalid, 1'b0);
        chk({tag, "_s_rready"}, s_if.rready, rr);
        chk({tag, "_grant"}, grant, 2'b01);
        if (rv && rr) begin
            chk({tag, "_rdata"}, m0_if.rdata, exp_beats[nbeat]);
            nbeat++;
        end
        step();
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
`else
        exp_g = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
`endif
        exp_beats = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};

        // Reset state
        rst_n = 1'b1;
        clear_inputs();
        #1 rst_n = 1'b0;
        step();
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_arvalid", s_if.arvalid, 1'b0);
        chk("rst_s_rready", s_if.rready, 1'b0);
        chk("rst_m0_arready", m0_if.arready, 1'b0);
        chk("rst_m1_rvalid", m1_if.rvalid, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // 1: M0 alone, single beat
        m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0000; m0_if.arid = 4'h3;
        #1;
        chk("t1_idle_s_arvalid", s_if.arvalid, 1'b0);
        chk("t1_idle_grant", grant, 2'b00);
        step();
        chk("t1_grant", grant, 2'b01);
        chk("t1_s_arvalid", s_if.arvalid, 1'b1);
        chk("t1_s_araddr", s_if.araddr, 32'h8000_0000);
        chk("t1_s_arid", s_if.arid, 4'h3);
        chk("t1_m0_arready_wait", m0_if.arready, 1'b0);
        s_if.arready = 1;
        #1;
        chk("t1_m0_arready", m0_if.arready, 1'b1);
        chk("t1_m1_arready", m1_if.arready, 1'b0);
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'hDEAD_BEEF; s_if.rlast = 1; m0_if.rready = 1;
        #1;
        chk("t1_data_s_arvalid", s_if.arvalid, 1'b0);
        chk("t1_m0_rvalid", m0_if.rvalid, 1'b1);
        chk("t1_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        chk("t1_m1_rvalid", m1_if.rvalid, 1'b0);
        chk("t1_s_rready", s_if.rready, 1'b1);
        step();
        s_if.rvalid = 0; s_if.rlast = 0; m0_if.rready = 0;
        chk("t1_grant_end", grant, 2'b00);

        // 2: simultaneous requests, always-ready slave
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_1000;
        m1_if.arvalid = 1; m1_if.araddr = 32'h0000_2000;
        s_if.arready = 1; s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'h1234_5678;
        m0_if.rready = 1; m1_if.rready = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("t2_grant_%0d", i), grant, exp_g[i]);
            if (i % 3 == 1) begin
                chk($sformatf("t2_m1_rvalid_%0d", i), m1_if.rvalid, exp_g[i] == 2'b10);
                chk($sformatf("t2_m0_rvalid_%0d", i), m0_if.rvalid, exp_g[i] == 2'b01);
            end
            if (i == 0) chk("t2_s_araddr_first", s_if.araddr, 32'h0000_2000);
        end
        clear_inputs();
        step();
        chk("t2_idle", grant, 2'b00);

        // 3: M1 stalled in ADDR while M0 waits
        m1_if.arvalid = 1; m1_if.araddr = 32'h0000_3000;
        step();
        chk("t3_grant", grant, 2'b10);
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_4000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t3_hold_grant_%0d", i), grant, 2'b10);
            chk($sformatf("t3_hold_m0_arready_%0d", i), m0_if.arready, 1'b0);
            chk($sformatf("t3_hold_s_araddr_%0d", i), s_if.araddr, 32'h0000_3000);
            step();
        end
        s_if.arready = 1;
        #1;
        chk("t3_m1_arready", m1_if.arready, 1'b1);
        chk("t3_m0_arready", m0_if.arready, 1'b0);
        step();
        m1_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'h1111_2222; m1_if.rready = 1;
        #1;
        chk("t3_m1_rvalid", m1_if.rvalid, 1'b1);
        chk("t3_m0_rvalid", m0_if.rvalid, 1'b0);
        chk("t3_m0_rdata_bcast", m0_if.rdata, 32'h1111_2222);
        chk("t3_m0_arready_data", m0_if.arready, 1'b0);
        step();
        s_if.rvalid = 0; s_if.rlast = 0;
        chk("t3_grant_gap", grant, 2'b00);
        step();
        chk("t3_grant_m0", grant, 2'b01);
        s_if.arready = 1;
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'h3333_4444; m0_if.rready = 1;
        #1;
        chk("t3_m0_rvalid_served", m0_if.rvalid, 1'b1);
        step();
        clear_inputs();
        chk("t3_grant_end", grant, 2'b00);

        // 4: 4-beat burst with slave gaps and master backpressure
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_5000; m0_if.arlen = 8'd3;
        s_if.arready = 1;
        step();
        chk("t4_s_arlen", s_if.arlen, 8'd3);
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        beat("t4_gap0", 1'b0, 32'h0,         1'b0, 1'b1);
        beat("t4_b0",   1'b1, 32'hB000_0000, 1'b0, 1'b1);
        beat("t4_b1",   1'b1, 32'hB000_0001, 1'b0, 1'b1);
        beat("t4_stall",1'b1, 32'hB000_0002, 1'b0, 1'b0);
        beat("t4_b2",   1'b1, 32'hB000_0002, 1'b0, 1'b1);
        beat("t4_gap1", 1'b0, 32'h0,         1'b0, 1'b1);
        beat("t4_b3",   1'b1, 32'hB000_0003, 1'b1, 1'b1);
        clear_inputs();
        chk("t4_grant_end", grant, 2'b00);

        // 5: async reset in DATA after first beat
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_6000; m0_if.arlen = 8'd1;
        s_if.arready = 1;
        step();
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 0; s_if.rdata = 32'h5555_0000; m0_if.rready = 1;
        step();
        #1;
        chk("t5_beat2_pending", m0_if.rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m0_rvalid", m0_if.rvalid, 1'b0);
        chk("t5_rst_s_rready", s_if.rready, 1'b0);
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_s_arvalid", s_if.arvalid, 1'b0);
        step();
        rst_n = 1'b1;
        clear_inputs();
        m1_if.arvalid = 1; m1_if.araddr = 32'h0000_7000;
        step();
        chk("t5_regrant", grant, 2'b10);
        chk("t5_regrant_s_arvalid", s_if.arvalid, 1'b1);

        // 6: owner drops arvalid in ADDR
        m1_if.arvalid = 0;
        #1;
        chk("t6_s_arvalid", s_if.arvalid, 1'b0);
        chk("t6_m1_arready", m1_if.arready, 1'b0);
        step();
        chk("t6_grant", grant, 2'b00);
        step();
        chk("t6_grant_stays", grant, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
